// File: rtl/counter_ctrl_unit_pkg.sv
// Shared definitions for the counter control front-end and the counter top:
// FSM state encoding, button indices and the debounce tick divisor.
package counter_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    // Button slot indices in the debouncer array
    localparam int BTN_RUN   = 0;
    localparam int BTN_CLR   = 1;
    localparam int BTN_MODE  = 2;
    localparam int NUM_BTN   = 3;

    // Default build: 100 MHz clock, 1 kHz sampling, 8 equal samples
    localparam int DEF_CLK_FREQ  = 100_000_000;
    localparam int DEF_SAMPLE_HZ = 1000;
    localparam int DEF_DB_DEPTH  = 8;

    // Clock cycles per debounce sample; must come out >= 2
    function automatic int calc_div(input int clk_freq, input int sample_hz);
        return clk_freq / sample_hz;
    endfunction

    localparam int DIV = calc_div(DEF_CLK_FREQ, DEF_SAMPLE_HZ);

endpackage

// File: rtl/counter_ctrl_unit_if.sv
// Button inputs and control outputs of the counter control stage.
// master = whoever drives the buttons, slave = the control unit itself.
interface counter_ctrl_unit_if;
    logic       btn_run_stop;
    logic       btn_clear;
    logic       btn_mode;
    logic       enable;
    logic       clear;
    logic       mode;
    logic [1:0] state;

    modport master (
        output btn_run_stop, btn_clear, btn_mode,
        input  enable, clear, mode, state
    );

    modport slave (
        input  btn_run_stop, btn_clear, btn_mode,
        output enable, clear, mode, state
    );
endinterface

// File: rtl/counter_ctrl_unit_debounce.sv
// One push-button channel: 2-flop synchroniser, tick-sampled debouncer that
// needs DB_DEPTH equal samples to change level, and rising-edge detector.
module btn_debounce #(
    parameter int DB_DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press
);

    logic [1:0]          sync_q;
    logic [DB_DEPTH-1:0] shift_q, shift_d;
    logic                level_q, level_d;
    logic                level_dly_q;

    // Bring the asynchronous button into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], btn_in};
    end

    // Sample on tick; the level only moves once the whole window agrees,
    // judged on the window including the sample just taken
    always_comb begin
        shift_d = shift_q;
        level_d = level_q;
        if (tick) begin
            shift_d = {shift_q[DB_DEPTH-2:0], sync_q[1]};
            if (&shift_d)       level_d = 1'b1;
            else if (~|shift_d) level_d = 1'b0;
        end
    end

    // Debounce window, debounced level and its one-cycle delayed copy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q     <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
        end
    end

    assign btn_level = level_q;
    // High for the single cycle after the debounced level rises
    assign btn_press = level_q & ~level_dly_q;

endmodule

// File: rtl/counter_ctrl_unit.sv
// Counter front-end control: shared debounce tick, three button channels,
// run/stop/clear FSM and the count-direction toggle.
module counter_ctrl_unit
    import counter_pkg::*;
#(
    parameter int CLK_FREQ  = DEF_CLK_FREQ,
    parameter int SAMPLE_HZ = DEF_SAMPLE_HZ,
    parameter int DB_DEPTH  = DEF_DB_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_ctrl_unit_if.slave   bus
);

    localparam int LDIV = calc_div(CLK_FREQ, SAMPLE_HZ);
    localparam int CW   = (LDIV <= 2) ? 1 : $clog2(LDIV);

    logic [CW-1:0]        tick_cnt_q, tick_cnt_d;
    logic                 tick;
    logic [NUM_BTN-1:0]   btn_raw;
    logic [NUM_BTN-1:0]   btn_lvl_unused;
    logic [NUM_BTN-1:0]   btn_prs;
    state_e               state_q, state_d;
    logic                 mode_q, mode_d;

    assign tick       = (tick_cnt_q == CW'(LDIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    // Free-running sample divisor, shared by all button channels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tick_cnt_q <= '0;
        else     tick_cnt_q <= tick_cnt_d;
    end

    assign btn_raw[BTN_RUN]  = bus.btn_run_stop;
    assign btn_raw[BTN_CLR]  = bus.btn_clear;
    assign btn_raw[BTN_MODE] = bus.btn_mode;

    btn_debounce #(.DB_DEPTH(DB_DEPTH)) u_db [NUM_BTN-1:0] (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .btn_in    (btn_raw),
        .btn_level (btn_lvl_unused),
        .btn_press (btn_prs)
    );

    // Run toggles STOP/RUN; clear only from STOP and lasts one cycle;
    // run wins over clear when both land together
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: begin
                if (btn_prs[BTN_RUN])      state_d = ST_RUN;
                else if (btn_prs[BTN_CLR]) state_d = ST_CLEAR;
            end
            ST_RUN: begin
                if (btn_prs[BTN_RUN])      state_d = ST_STOP;
            end
            ST_CLEAR: state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase
        mode_d = mode_q ^ btn_prs[BTN_MODE];
    end

    // State and direction registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STOP;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.enable = (state_q == ST_RUN);
    assign bus.clear  = (state_q == ST_CLEAR);
    assign bus.mode   = mode_q;
    assign bus.state  = state_q;

endmodule

// File: tb/tb_counter_ctrl_unit.sv
// Directed bench for counter_ctrl_unit with DIV=10, DB_DEPTH=4.
module tb_counter_ctrl_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    // Activity recorded by the monitor, cleared by each scenario
    int   clr_cyc   = 0;
    int   en_rise   = 0;
    int   st_chg    = 0;
    bit   seen2     = 1'b0;
    bit   nonzero   = 1'b0;
    logic       en_prev = 1'b0;
    logic [1:0] st_prev = 2'd0;

    counter_ctrl_unit_if ifc ();

    counter_ctrl_unit #(
        .CLK_FREQ  (1000),
        .SAMPLE_HZ (100),
        .DB_DEPTH  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    // Record output activity on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            en_prev = 1'b0;
            st_prev = 2'd0;
        end else begin
            if (ifc.clear === 1'b1) clr_cyc++;
            if (ifc.enable === 1'b1 && en_prev === 1'b0) en_rise++;
            if (ifc.state !== st_prev) st_chg++;
            if (ifc.state === 2'd2) seen2 = 1'b1;
            if (ifc.state !== 2'd0) nonzero = 1'b1;
            en_prev = ifc.enable;
            st_prev = ifc.state;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        clr_cyc = 0; en_rise = 0; st_chg = 0; seen2 = 1'b0; nonzero = 1'b0;
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: ifc.btn_run_stop = v;
            1: ifc.btn_clear    = v;
            default: ifc.btn_mode = v;
        endcase
    endtask

    // Clean press long enough for a debounced press and release
    task automatic press(input int which);
        set_btn(which, 1'b1);
        wait_cyc(80);
        set_btn(which, 1'b0);
        wait_cyc(80);
    endtask

    task automatic test_reset();
        ifc.btn_run_stop = 1'b0; ifc.btn_clear = 1'b0; ifc.btn_mode = 1'b0;
        rst = 1'b1;
        #3;
        n_vec++; if (ifc.enable !== 1'b0) begin n_err++; $display("FAIL reset_enable got=%b exp=0", ifc.enable); end
        n_vec++; if (ifc.clear !== 1'b0) begin n_err++; $display("FAIL reset_clear got=%b exp=0", ifc.clear); end
        n_vec++; if (ifc.mode !== 1'b0) begin n_err++; $display("FAIL reset_mode got=%b exp=0", ifc.mode); end
        n_vec++; if (ifc.state !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", ifc.state); end
        wait_cyc(3);
        @(negedge clk); rst = 1'b0;
        wait_cyc(50);
        n_vec++; if (ifc.state !== 2'd0 || ifc.mode !== 1'b0) begin
            n_err++; $display("FAIL idle_after_reset state=%0d mode=%b exp 0/0", ifc.state, ifc.mode); end
    endtask

    task automatic test_run_toggle();
        clr_mon();
        ifc.btn_run_stop = 1'b1; wait_cyc(100);
        n_vec++; if (ifc.state !== 2'd1 || ifc.enable !== 1'b1) begin
            n_err++; $display("FAIL run_start state=%0d en=%b exp 1/1", ifc.state, ifc.enable); end
        n_vec++; if (st_chg !== 1 || en_rise !== 1) begin
            n_err++; $display("FAIL run_start_once chg=%0d rise=%0d exp 1/1", st_chg, en_rise); end
        ifc.btn_run_stop = 1'b0; wait_cyc(100);
        n_vec++; if (st_chg !== 1) begin n_err++; $display("FAIL release_no_event chg=%0d exp 1", st_chg); end
        ifc.btn_run_stop = 1'b1; wait_cyc(100);
        n_vec++; if (ifc.state !== 2'd0 || ifc.enable !== 1'b0) begin
            n_err++; $display("FAIL run_stop state=%0d en=%b exp 0/0", ifc.state, ifc.enable); end
        n_vec++; if (st_chg !== 2 || en_rise !== 1) begin
            n_err++; $display("FAIL run_stop_once chg=%0d rise=%0d exp 2/1", st_chg, en_rise); end
        ifc.btn_run_stop = 1'b0; wait_cyc(100);
    endtask

    task automatic test_mode();
        press(2);
        n_vec++; if (ifc.mode !== 1'b1 || ifc.enable !== 1'b0) begin
            n_err++; $display("FAIL mode_stop mode=%b en=%b exp 1/0", ifc.mode, ifc.enable); end
        press(0);
        press(2);
        n_vec++; if (ifc.mode !== 1'b0 || ifc.enable !== 1'b1) begin
            n_err++; $display("FAIL mode_run mode=%b en=%b exp 0/1", ifc.mode, ifc.enable); end
        press(0);
        press(2);
        n_vec++; if (ifc.mode !== 1'b1 || ifc.enable !== 1'b0) begin
            n_err++; $display("FAIL mode_stop2 mode=%b en=%b exp 1/0", ifc.mode, ifc.enable); end
    endtask

    task automatic test_bounce();
        clr_mon();
        for (int i = 0; i < 20; i++) begin
            ifc.btn_clear = ~ifc.btn_clear;
            wait_cyc(15);
        end
        n_vec++; if (clr_cyc !== 0 || nonzero !== 1'b0) begin
            n_err++; $display("FAIL bounce_reject clr=%0d nonzero=%b exp 0/0", clr_cyc, nonzero); end
        ifc.btn_clear = 1'b1; wait_cyc(60);
        n_vec++; if (clr_cyc !== 1) begin n_err++; $display("FAIL clear_width got=%0d exp=1", clr_cyc); end
        n_vec++; if (seen2 !== 1'b1 || st_chg !== 2 || ifc.state !== 2'd0) begin
            n_err++; $display("FAIL clear_seq seen2=%b chg=%0d state=%0d exp 1/2/0", seen2, st_chg, ifc.state); end
        ifc.btn_clear = 1'b0; wait_cyc(80);
    endtask

    task automatic test_clear_in_run();
        press(0);
        clr_mon();
        press(1);
        n_vec++; if (clr_cyc !== 0 || ifc.enable !== 1'b1 || ifc.state !== 2'd1) begin
            n_err++; $display("FAIL clear_in_run clr=%0d en=%b state=%0d exp 0/1/1", clr_cyc, ifc.enable, ifc.state); end
        press(0);
        n_vec++; if (ifc.state !== 2'd0) begin n_err++; $display("FAIL run_to_stop state=%0d exp=0", ifc.state); end
    endtask

    task automatic test_simultaneous();
        clr_mon();
        ifc.btn_run_stop = 1'b1; ifc.btn_clear = 1'b1;
        wait_cyc(80);
        n_vec++; if (ifc.state !== 2'd1 || clr_cyc !== 0 || seen2 !== 1'b0) begin
            n_err++; $display("FAIL simultaneous state=%0d clr=%0d seen2=%b exp 1/0/0", ifc.state, clr_cyc, seen2); end
        ifc.btn_run_stop = 1'b0; ifc.btn_clear = 1'b0;
        wait_cyc(80);
    endtask

    task automatic test_reset_mid();
        ifc.btn_run_stop = 1'b1;
        wait_cyc(20);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        n_vec++; if (ifc.enable !== 1'b0 || ifc.mode !== 1'b0 || ifc.state !== 2'd0) begin
            n_err++; $display("FAIL async_reset en=%b mode=%b state=%0d exp 0/0/0", ifc.enable, ifc.mode, ifc.state); end
        wait_cyc(3);
        @(negedge clk); rst = 1'b0;
        wait_cyc(40);
        n_vec++; if (ifc.state !== 2'd0) begin n_err++; $display("FAIL early_press state=%0d exp=0", ifc.state); end
        wait_cyc(1);
        n_vec++; if (ifc.state !== 2'd1 || ifc.enable !== 1'b1) begin
            n_err++; $display("FAIL post_reset_press state=%0d en=%b exp 1/1", ifc.state, ifc.enable); end
        ifc.btn_run_stop = 1'b0;
        wait_cyc(20);
    endtask

    initial begin
        test_reset();
        test_run_toggle();
        test_mode();
        test_bounce();
        test_clear_in_run();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
